main_fsm: RTL and testbench

- Multicycle main controller FSM in the Control-Unit. Sequences each instruction through fetch, decode and execute steps.
- Drives datapath mux selects and write enables.
- Produces ALUOp, which is consumed directly by the ALU decoder; Funct is passed to that decoder unchanged.
- Adds a memory-ready handshake so instruction and data memory may take more than one cycle.

---
 rtl/main_fsm.sv | 141 ++++++++++++++
 tb/tb_main_fsm.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/main_fsm.sv
// Multicycle main controller: sequences fetch/decode/execute and decodes the
// datapath selects and write requests from the current state.
module main_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               MemReady,
    output logic               IRWrite,
    output logic               NextPC,
    output logic               AdrSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic               ALUOp,
    output logic               RegW,
    output logic               MemW,
    output logic               Branch,
    output logic               Illegal,
    output logic               InstrDone,
    output logic [STATE_W-1:0] State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_e;

    state_e state_q;
    state_e state_d;

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode from the current state.
    always_comb begin
        state_d   = FETCH;
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        ALUOp     = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        Illegal   = 1'b0;
        InstrDone = 1'b0;
        case (state_q)
            FETCH: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                NextPC    = MemReady;
                state_d   = MemReady ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b00:   state_d = Funct[5] ? EXECI : EXECR;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: begin
                        Illegal   = 1'b1;
                        InstrDone = 1'b1;
                        state_d   = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc  = 1'b1;
                state_d = MemReady ? MEMWB : MEMRD;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
                InstrDone = 1'b1;
                state_d   = FETCH;
            end
            MEMWR: begin
                // Write request is held for the whole wait so slow memory sees it.
                AdrSrc    = 1'b1;
                MemW      = 1'b1;
                InstrDone = MemReady;
                state_d   = MemReady ? FETCH : MEMWR;
            end
            EXECR: begin
                ALUOp   = 1'b1;
                state_d = ALUWB;
            end
            EXECI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
                state_d = ALUWB;
            end
            ALUWB: begin
                RegW      = 1'b1;
                InstrDone = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = 1'b1;
                InstrDone = 1'b1;
                state_d   = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign State = STATE_W'(state_q);

endmodule

// File: tb/tb_main_fsm.sv
// Randomized bench for main_fsm: an instruction-level model builds the expected
// per-cycle trace and latency for each instruction class and wait pattern.
module tb_main_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] op;
    logic [5:0] funct;
    logic       mem_ready;
    logic       ir_write, next_pc, adr_src, alu_op, reg_w, mem_w, branch, illegal, instr_done;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [3:0] state;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [3:0] st;
        logic       irw;
        logic       npc;
        logic       adr;
        logic [1:0] asa;
        logic [1:0] asb;
        logic [1:0] rs;
        logic       aluop;
        logic       regw;
        logic       memw;
        logic       br;
        logic       ill;
        logic       done;
    } out_t;

    typedef struct packed {
        logic mr;
        out_t o;
    } rec_t;

    rec_t q[$];

    main_fsm #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .Op(op), .Funct(funct), .MemReady(mem_ready),
        .IRWrite(ir_write), .NextPC(next_pc), .AdrSrc(adr_src),
        .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b), .ResultSrc(result_src),
        .ALUOp(alu_op), .RegW(reg_w), .MemW(mem_w), .Branch(branch),
        .Illegal(illegal), .InstrDone(instr_done), .State(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic out_t observed();
        out_t o;
        o = '{st: state, irw: ir_write, npc: next_pc, adr: adr_src, asa: alu_src_a,
              asb: alu_src_b, rs: result_src, aluop: alu_op, regw: reg_w,
              memw: mem_w, br: branch, ill: illegal, done: instr_done};
        return o;
    endfunction

    function automatic out_t blank(input logic [3:0] st);
        out_t o;
        o = '0;
        o.st = st;
        return o;
    endfunction

    function automatic out_t fetch_out(input logic mr);
        out_t o;
        o = blank(4'd0);
        o.asa = 2'b01; o.asb = 2'b10; o.rs = 2'b10;
        o.irw = mr; o.npc = mr;
        return o;
    endfunction

    task automatic add(input logic mr, input out_t o);
        rec_t r;
        r.mr = mr;
        r.o  = o;
        q.push_back(r);
    endtask

    // Expected cycle-by-cycle trace for one instruction with given wait counts.
    task automatic build(input logic [1:0] iop, input logic [5:0] ifn, input int fw, input int mw);
        out_t o;
        logic mr;
        q.delete();
        for (int i = 0; i <= fw; i++) begin
            mr = (i == fw);
            add(mr, fetch_out(mr));
        end
        o = blank(4'd1);
        o.asa = 2'b01; o.asb = 2'b10; o.rs = 2'b10;
        if (iop == 2'b11) begin
            o.ill = 1'b1; o.done = 1'b1;
        end
        add(1'($urandom_range(0, 1)), o);
        if (iop == 2'b00) begin
            o = blank(ifn[5] ? 4'd7 : 4'd6);
            o.asb = ifn[5] ? 2'b01 : 2'b00; o.aluop = 1'b1;
            add(1'($urandom_range(0, 1)), o);
            o = blank(4'd8);
            o.regw = 1'b1; o.done = 1'b1;
            add(1'($urandom_range(0, 1)), o);
        end else if (iop == 2'b01) begin
            o = blank(4'd2);
            o.asb = 2'b01;
            add(1'($urandom_range(0, 1)), o);
            for (int i = 0; i <= mw; i++) begin
                mr = (i == mw);
                o = blank(ifn[0] ? 4'd3 : 4'd5);
                o.adr = 1'b1;
                if (!ifn[0]) begin
                    o.memw = 1'b1; o.done = mr;
                end
                add(mr, o);
            end
            if (ifn[0]) begin
                o = blank(4'd4);
                o.rs = 2'b01; o.regw = 1'b1; o.done = 1'b1;
                add(1'($urandom_range(0, 1)), o);
            end
        end else if (iop == 2'b10) begin
            o = blank(4'd9);
            o.asa = 2'b10; o.asb = 2'b01; o.rs = 2'b10; o.br = 1'b1; o.done = 1'b1;
            add(1'($urandom_range(0, 1)), o);
        end
    endtask

    function automatic int latency(input logic [1:0] iop, input logic [5:0] ifn, input int fw, input int mw);
        case (iop)
            2'b00:   return 4 + fw;
            2'b01:   return (ifn[0] ? 5 : 4) + fw + mw;
            2'b10:   return 3 + fw;
            default: return 2 + fw;
        endcase
    endfunction

    // Runs one instruction; with abort set, reset is raised in the first MEMWR cycle.
    task automatic run_instr(input logic [1:0] iop, input logic [5:0] ifn, input int fw,
                             input int mw, input bit abort);
        int done_at;
        done_at = -1;
        build(iop, ifn, fw, mw);
        for (int i = 0; i < q.size(); i++) begin
            mem_ready = q[i].mr;
            if (q[i].o.st == 4'd0) begin
                op    = 2'($urandom_range(0, 3));
                funct = 6'($urandom_range(0, 63));
            end else begin
                op    = iop;
                funct = ifn;
            end
            reset = abort && (q[i].o.st == 4'd5);
            @(negedge clk);
            chk($sformatf("cycle%0d_op%0d", i, iop), 32'(observed()), 32'(q[i].o));
            if (instr_done === 1'b1 && done_at < 0) done_at = i;
            @(posedge clk);
            #1;
            if (reset) begin
                reset = 1'b0;
                break;
            end
        end
        if (abort) begin
            mem_ready = 1'b0;
            @(negedge clk);
            chk("post_reset", 32'(observed()), 32'(fetch_out(1'b0)));
            @(posedge clk);
            #1;
        end else begin
            chk($sformatf("latency_op%0d", iop), 32'(done_at + 1), 32'(latency(iop, ifn, fw, mw)));
        end
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b0;
        op        = 2'b00;
        funct     = 6'b000000;
        @(posedge clk); #1;
        @(negedge clk);
        chk("in_reset", 32'(observed()), 32'(fetch_out(1'b0)));
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("after_reset", 32'(observed()), 32'(fetch_out(1'b0)));
        @(posedge clk); #1;

        run_instr(2'b00, 6'b101000, 0, 0, 1'b0);
        run_instr(2'b00, 6'b001000, 0, 0, 1'b0);
        run_instr(2'b01, 6'b011001, 0, 3, 1'b0);
        run_instr(2'b01, 6'b011000, 0, 2, 1'b0);
        run_instr(2'b10, 6'b000000, 1, 0, 1'b0);
        run_instr(2'b11, 6'b101001, 0, 0, 1'b0);
        run_instr(2'b01, 6'b011000, 0, 2, 1'b1);
        run_instr(2'b00, 6'b000100, 2, 0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            run_instr(2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
                      $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        end
        run_instr(2'b01, 6'b000000, 1, 1, 1'b1);
        run_instr(2'b10, 6'b000000, 0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
